// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 16-bit memory between the IF-stage
// instruction fetch and the MM-stage load/store. Each access runs through a
// request/ready handshake, returns registered read data with a one-cycle ack,
// and is guarded by a watchdog that ends accesses that never see mem_ready.
// Optional feature macro: ARB_FAIR_EN -- round-robin between fetch and data
// when both are pending; left undefined, data always wins over fetch.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              mm_read,
    input  logic              mm_write,
    input  logic [ADDR_W-1:0] mm_addr,
    input  logic [DATA_W-1:0] mm_wdata,
    output logic [DATA_W-1:0] mm_rdata,
    output logic              mm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mm,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA,
        RESP
    } ArbState;

    // Last access cycle before the watchdog gives up (MAX_WAIT access cycles in total).
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    ArbState    state;
    ArbState    stateNext;
    logic [7:0] waitCount;
    logic       dataPending;
    logic       grantData;
    logic       grantFetch;
    logic       accessDone;
    logic       accessTimeout;

`ifdef ARB_FAIR_EN
    logic       lastGrantData;
`endif

    assign dataPending = mm_read | mm_write;
    assign mem_en      = (state == FETCH) || (state == DATA);
    assign stall_if    = if_req & ~if_ack;
    assign stall_mm    = dataPending & ~mm_ack;

    // State register; reset aborts whatever access was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Arbitration, handshake completion and watchdog decisions.
    always_comb begin
        stateNext     = state;
        grantData     = 1'b0;
        grantFetch    = 1'b0;
        accessDone    = 1'b0;
        accessTimeout = 1'b0;
        case (state)
            IDLE: begin
`ifdef ARB_FAIR_EN
                if (dataPending && if_req) begin
                    grantFetch = lastGrantData;
                    grantData  = ~lastGrantData;
                end else begin
                    grantData  = dataPending;
                    grantFetch = if_req;
                end
`else
                grantData  = dataPending;
                grantFetch = if_req & ~dataPending;
`endif
                if (grantData) begin
                    stateNext = DATA;
                end else if (grantFetch) begin
                    stateNext = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ready) begin
                    accessDone = 1'b1;
                    stateNext  = RESP;
                end else if (waitCount == WAIT_LAST) begin
                    accessTimeout = 1'b1;
                    stateNext     = RESP;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Memory-side registers, read data capture, acks, watchdog counter and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCount <= 8'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            if_rdata  <= '0;
            mm_rdata  <= '0;
            if_ack    <= 1'b0;
            mm_ack    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            if_ack <= (state == FETCH) && (accessDone || accessTimeout);
            mm_ack <= (state == DATA) && (accessDone || accessTimeout);

            if (mem_en) begin
                waitCount <= waitCount + 8'd1;
            end else begin
                waitCount <= 8'd0;
            end

            if (grantData) begin
                mem_addr  <= mm_addr;
                mem_wdata <= mm_wdata;
                mem_we    <= mm_write;
                if (mm_read && mm_write) begin
                    bus_err <= 1'b1;
                end
            end else if (grantFetch) begin
                mem_addr <= if_addr;
                mem_we   <= 1'b0;
            end

            if (accessDone) begin
                if (state == FETCH) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    mm_rdata <= mem_rdata;
                end
            end

            if (accessTimeout) begin
                bus_err <= 1'b1;
                if (state == FETCH) begin
                    if_rdata <= '0;
                end else if (!mem_we) begin
                    mm_rdata <= '0;
                end
            end
        end
    end

`ifdef ARB_FAIR_EN
    // Remember who was granted last so a simultaneous request alternates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrantData <= 1'b1;
        end else if (grantData) begin
            lastGrantData <= 1'b1;
        end else if (grantFetch) begin
            lastGrantData <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified 16-bit memory between the IF-stage instruction fetch and the MM-stage load/store.
- Sequences each access through a request/ready handshake and returns registered read data and a one-cycle ack.
- Drives per-stage stall outputs into the pipeline stall logic.
- A watchdog catches memory accesses that never complete.

Parameters:
- ADDR_W, 16, memory address width (byte address, same as PC)
- DATA_W, 16, memory data width
- MAX_WAIT, 15, cycles to wait for mem_ready before timeout (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, level-held until if_ack
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- mm_read  in  1  load request, level-held until mm_ack
- mm_write  in  1  store request, level-held until mm_ack
- mm_addr  in  ADDR_W  data address (ALU result)
- mm_wdata  in  DATA_W  store data
- mm_rdata  out  DATA_W  load data, valid with mm_ack
- mm_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes the current access
- stall_if  out  1  IF must hold: if_req & ~if_ack
- stall_mm  out  1  pipeline must freeze: (mm_read|mm_write) & ~mm_ack
- bus_err  out  1  sticky error flag

Behaviour:
Reset:
- Asynchronous on rst_n low. FSM goes to IDLE and any in-flight access is aborted.
- Wait counter = 0.
- if_rdata, mm_rdata, mem_addr, mem_wdata = 0.
- if_ack, mm_ack, mem_en, mem_we, bus_err = 0.
- last_grant = DATA.

FSM states: IDLE, FETCH, DATA, RESP.
- IDLE
  - If mm_read|mm_write: latch mm_addr and mm_wdata, set mem_we = mm_write, go to DATA.
  - Else if if_req: latch if_addr, set mem_we = 0, go to FETCH.
  - Else stay in IDLE.
  - Data has fixed priority (older instruction).
- FETCH / DATA
  - mem_en = 1. mem_addr, mem_wdata and mem_we are registered and held stable for the whole access.
  - Counter increments each cycle.
  - On mem_ready:
    - Capture mem_rdata into if_rdata (FETCH), or into mm_rdata (DATA read only).
    - Pulse the matching ack in the next cycle and go to RESP.
  - On counter == MAX_WAIT without mem_ready:
    - Set bus_err.
    - Capture 0 as read data, ack, go to RESP.
- RESP
  - The ack is high for exactly this cycle; mem_en = 0.
  - Requests are not sampled, so an ack'd request is never reissued.
  - Next state is IDLE. Counter clears.

Latency:
- Request seen in IDLE at cycle 0 → mem_en high at cycle 1.
- With mem_ready at cycle 1 → ack at cycle 2.
- Minimum 3 cycles per access, back-to-back (IDLE, access, RESP).

Boundary and error cases:
- mm_read and mm_write both high: perform the write, set bus_err; mm_ack still pulses and mm_rdata is unchanged.
- Stores leave mm_rdata unchanged.
- A request dropped mid-access: the access still completes and the ack still pulses; the requester ignores it.
- mem_ready high while mem_en = 0 is ignored.
- bus_err clears only on reset.
- Addresses pass through unmodified; no alignment check.

Optional Feature:
ARB_FAIR_EN
- Defined: when both requests are pending in IDLE, grant the requester not equal to last_grant (round-robin); last_grant updates on every grant.
- Undefined: fixed data-over-fetch priority; last_grant is unused.

Test Plan:
- Fetch only: if_req = 1, if_addr = 0x0004, mem_ready = 1 in the first access cycle, mem_rdata = 0x1234 → mem_en at cycle 1, if_ack at cycle 2 with if_rdata = 0x1234; stall_if high cycles 0-1.
- Simultaneous: if_req = 1, mm_read = 1 at 0x0020 (mem returns 0xBEEF) → DATA served first, mm_ack with 0xBEEF, then the fetch is served; with ARB_FAIR_EN and last_grant = DATA, the fetch is served first.
- Store: mm_write = 1, mm_addr = 0x0040, mm_wdata = 0x00FF, mem_ready delayed 3 cycles → mem_we = 1, mem_addr = 0x0040, mem_wdata = 0x00FF held stable 4 cycles; mm_ack one cycle later; mm_rdata unchanged.
- Timeout: mm_read, mem_ready never asserted → after 15 access cycles bus_err = 1, mm_ack pulses with mm_rdata = 0; bus_err stays set.
- Reset mid-access: rst_n low during DATA → outputs 0 immediately, FSM in IDLE; after release, a pending if_req starts a fresh fetch.
- Protocol violation: mm_read = mm_write = 1 → write performed, bus_err = 1, single mm_ack.
